// File: rtl/neurotransmitter_level.sv
// neurotransmitter_level: saturating level integrator fed by a regulator's
// inc/dec/fast requests. It updates once per prescaler wrap, drifts toward
// BASELINE after IDLE_UPDATES request-free updates, and publishes a 2-bit
// hysteresis-quantized code.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              advance enable (0 freezes prescaler, idle counter, level)
//   inc, dec, fast  regulator requests, sampled only on update strobes
//   level           internal level register
//   level_q         quantized level (bus field), one cycle behind level
//   changed         one-cycle pulse when level_q changes
//   sat_hi, sat_lo  level at full scale / at zero
module neurotransmitter_level #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned RESET_LEVEL   = 128,
  parameter int unsigned BASELINE      = 128,
  parameter int unsigned PRESCALE_BITS = 4,
  parameter int unsigned SLOW_STEP     = 1,
  parameter int unsigned FAST_STEP     = 4,
  parameter int unsigned IDLE_UPDATES  = 8,
  parameter int unsigned HYST          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             fast,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       level_q,
  output logic             changed,
  output logic             sat_hi,
  output logic             sat_lo
);

  localparam int unsigned LW      = WIDTH + 1;
  localparam int unsigned IW      = (IDLE_UPDATES > 1) ? $clog2(IDLE_UPDATES) : 1;
  localparam int unsigned ZONE    = 1 << (WIDTH - 2);
  localparam logic [LW-1:0]    LVL_MAX = LW'((1 << WIDTH) - 1);
  localparam logic [WIDTH-1:0] BASE    = WIDTH'(BASELINE);

  logic [PRESCALE_BITS-1:0] pre;
  logic [IW-1:0]            idle_cnt;
  logic                     strobe_c;
  logic [LW-1:0]            level_ext;
  logic [LW-1:0]            step;
  logic [LW-1:0]            sum_up;
  logic [WIDTH-1:0]         level_nxt;
  logic [IW-1:0]            idle_nxt;
  logic [1:0]               q_up;
  logic [1:0]               q_dn;
  logic [1:0]               q_nxt;

  assign strobe_c  = en && (pre == '1);
  assign level_ext = {1'b0, level};
  assign step      = fast ? LW'(FAST_STEP) : LW'(SLOW_STEP);
  assign sum_up    = level_ext + step;

  // Level / idle-counter update on a strobe; dec dominates inc, clamped at both ends.
  always_comb begin
    level_nxt = level;
    idle_nxt  = idle_cnt;
    if (strobe_c) begin
      if (dec) begin
        level_nxt = (level_ext < step) ? '0 : WIDTH'(level_ext - step);
        idle_nxt  = '0;
      end else if (inc) begin
        level_nxt = (sum_up > LVL_MAX) ? '1 : WIDTH'(sum_up);
        idle_nxt  = '0;
      end else if (idle_cnt == IW'(IDLE_UPDATES - 1)) begin
        idle_nxt = '0;
        if (level > BASE) begin
          level_nxt = level - WIDTH'(1);
        end else if (level < BASE) begin
          level_nxt = level + WIDTH'(1);
        end
      end else begin
        idle_nxt = idle_cnt + IW'(1);
      end
    end
  end

  // Hysteresis quantizer: move up only past b_k+HYST, down only below b_k-HYST.
  always_comb begin
    q_up = '0;
    q_dn = '0;
    for (int k = 1; k <= 3; k++) begin
      if (level_ext >= LW'(k * ZONE + HYST)) q_up = q_up + 2'd1;
      if (level_ext >= LW'(k * ZONE - HYST)) q_dn = q_dn + 2'd1;
    end
    q_nxt = level_q;
    if (q_up > level_q) begin
      q_nxt = q_up;
    end else if (q_dn < level_q) begin
      q_nxt = q_dn;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre      <= '0;
      idle_cnt <= '0;
      level    <= WIDTH'(RESET_LEVEL);
      level_q  <= 2'(RESET_LEVEL >> (WIDTH - 2));
      changed  <= 1'b0;
    end else begin
      if (en) pre <= pre + PRESCALE_BITS'(1);
      idle_cnt <= idle_nxt;
      level    <= level_nxt;
      level_q  <= q_nxt;
      changed  <= (q_nxt != level_q);
    end
  end

  assign sat_hi = (level == '1);
  assign sat_lo = (level == '0);

endmodule

// File: tb/tb_neurotransmitter_level.sv
module tb_neurotransmitter_level;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       inc;
  logic       dec;
  logic       fast;
  logic [7:0] level;
  logic [1:0] level_q;
  logic       changed;
  logic       sat_hi;
  logic       sat_lo;

  int checks   = 0;
  int errors   = 0;
  int sb_bad   = 0;
  int timeouts = 0;
  int chg_cnt  = 0;
  int c0;

  // Scoreboard: expected level pushed by the reference model at each strobe.
  int exp_q[$];
  int m_pre, m_level, m_idle;

  always #5 clk = ~clk;

  neurotransmitter_level dut (
    .clk(clk), .rst(rst), .en(en), .inc(inc), .dec(dec), .fast(fast),
    .level(level), .level_q(level_q), .changed(changed),
    .sat_hi(sat_hi), .sat_lo(sat_lo)
  );

  function automatic int model_next(input int lvl, input bit i, input bit d,
                                    input bit f, input bit drift);
    int s;
    s = f ? 4 : 1;
    if (d) return (lvl - s < 0) ? 0 : lvl - s;
    if (i) return (lvl + s > 255) ? 255 : lvl + s;
    if (drift) return (lvl > 128) ? lvl - 1 : (lvl < 128) ? lvl + 1 : lvl;
    return lvl;
  endfunction

  // Reference model of prescaler, idle counter and level.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre   <= 0;
      m_level <= 128;
      m_idle  <= 0;
      exp_q.delete();
    end else if (en) begin
      m_pre <= (m_pre + 1) % 16;
      if (m_pre == 15) begin
        m_level <= model_next(m_level, inc, dec, fast, !inc && !dec && m_idle == 7);
        exp_q.push_back(model_next(m_level, inc, dec, fast, !inc && !dec && m_idle == 7));
        m_idle <= (inc || dec) ? 0 : (m_idle == 7) ? 0 : m_idle + 1;
      end
    end
  end

  always @(negedge clk) if (!rst && changed) chg_cnt <= chg_cnt + 1;

  // Waits for n model strobes and compares the DUT level against each one.
  task automatic advance(input int n);
    int e;
    int x;
    for (int s = 0; s < n; s++) begin
      e = 0;
      while (exp_q.size() == 0 && e < 64) begin
        @(posedge clk); #1; e++;
      end
      if (exp_q.size() == 0) timeouts++;
      else begin
        x = exp_q.pop_front();
        if (int'(level) != x) begin
          sb_bad++;
          $display("FAIL scoreboard_level got %0d exp %0d at %0t", level, x, $time);
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; inc = 1'b0; dec = 1'b0; fast = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_bad = 0; timeouts = 0;
  endtask

  task automatic test_reset();
    int stable;
    apply_reset();
    checks++; if (level !== 8'd128) begin errors++; $display("FAIL reset_level got %0d exp 128", level); end
    checks++; if (level_q !== 2'd2) begin errors++; $display("FAIL reset_level_q got %0d exp 2", level_q); end
    checks++; if ({sat_hi, sat_lo, changed} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {sat_hi, sat_lo, changed}); end
    inc = 1'b1;
    stable = 1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (level !== 8'd128) stable = 0;
    end
    checks++; if (stable !== 1) begin errors++; $display("FAIL early_update got %0d exp 1", stable); end
    @(posedge clk); #1;
    checks++; if (level !== 8'd129) begin errors++; $display("FAIL first_strobe got %0d exp 129", level); end
    checks++; if (exp_q.size() !== 1) begin errors++; $display("FAIL first_strobe_sb got %0d exp 1", exp_q.size()); end
    else void'(exp_q.pop_front());
  endtask

  task automatic test_slow_inc();
    c0 = chg_cnt;
    advance(15);
    checks++; if (level !== 8'd144) begin errors++; $display("FAIL slow_inc_level got %0d exp 144", level); end
    @(posedge clk); #1;
    checks++; if (level_q !== 2'd2) begin errors++; $display("FAIL slow_inc_q got %0d exp 2", level_q); end
    checks++; if (chg_cnt - c0 !== 0) begin errors++; $display("FAIL slow_inc_changed got %0d exp 0", chg_cnt - c0); end
    checks++; if (sb_bad + timeouts !== 0) begin errors++; $display("FAIL slow_inc_sb got %0d exp 0", sb_bad + timeouts); end
  endtask

  task automatic test_fast_sat();
    apply_reset();
    inc = 1'b1; fast = 1'b1;
    c0 = chg_cnt;
    advance(17);
    checks++; if (level !== 8'd196) begin errors++; $display("FAIL fast_level got %0d exp 196", level); end
    checks++; if (level_q !== 2'd2) begin errors++; $display("FAIL fast_q_latency got %0d exp 2", level_q); end
    @(posedge clk); #1;
    checks++; if ({level_q, changed} !== 3'b111) begin errors++; $display("FAIL fast_q_change got %b exp 111", {level_q, changed}); end
    @(posedge clk); #1;
    checks++; if (changed !== 1'b0) begin errors++; $display("FAIL fast_changed_width got %b exp 0", changed); end
    advance(15);
    checks++; if ({level, sat_hi} !== {8'd255, 1'b1}) begin errors++; $display("FAIL fast_sat got %0d/%b exp 255/1", level, sat_hi); end
    advance(2);
    checks++; if (level !== 8'd255) begin errors++; $display("FAIL fast_hold got %0d exp 255", level); end
    checks++; if (chg_cnt - c0 !== 1) begin errors++; $display("FAIL fast_pulses got %0d exp 1", chg_cnt - c0); end
    checks++; if (sb_bad + timeouts !== 0) begin errors++; $display("FAIL fast_sb got %0d exp 0", sb_bad + timeouts); end
  endtask

  task automatic test_hysteresis();
    apply_reset();
    inc = 1'b1; fast = 1'b1;
    advance(17);
    repeat (2) @(posedge clk); #1;
    inc = 1'b0; dec = 1'b1; fast = 1'b0;
    advance(8);
    @(posedge clk); #1;
    checks++; if ({level, level_q} !== {8'd188, 2'd3}) begin errors++; $display("FAIL hyst_188 got %0d/%0d exp 188/3", level, level_q); end
    advance(1);
    @(posedge clk); #1;
    checks++; if ({level, level_q, changed} !== {8'd187, 2'd2, 1'b1}) begin errors++; $display("FAIL hyst_187 got %0d/%0d/%b exp 187/2/1", level, level_q, changed); end
    dec = 1'b0; inc = 1'b1;
    advance(8);
    @(posedge clk); #1;
    checks++; if ({level, level_q} !== {8'd195, 2'd2}) begin errors++; $display("FAIL hyst_195 got %0d/%0d exp 195/2", level, level_q); end
    advance(1);
    @(posedge clk); #1;
    checks++; if ({level, level_q} !== {8'd196, 2'd3}) begin errors++; $display("FAIL hyst_196 got %0d/%0d exp 196/3", level, level_q); end
    checks++; if (sb_bad + timeouts !== 0) begin errors++; $display("FAIL hyst_sb got %0d exp 0", sb_bad + timeouts); end
  endtask

  task automatic test_priority_floor();
    apply_reset();
    inc = 1'b1; dec = 1'b1; fast = 1'b1;
    advance(1);
    checks++; if (level !== 8'd124) begin errors++; $display("FAIL priority got %0d exp 124", level); end
    inc = 1'b0;
    advance(30);
    fast = 1'b0;
    advance(2);
    checks++; if ({level, sat_lo} !== {8'd2, 1'b0}) begin errors++; $display("FAIL floor_pre got %0d/%b exp 2/0", level, sat_lo); end
    fast = 1'b1;
    advance(1);
    checks++; if ({level, sat_lo} !== {8'd0, 1'b1}) begin errors++; $display("FAIL floor_clamp got %0d/%b exp 0/1", level, sat_lo); end
    advance(1);
    checks++; if (level !== 8'd0) begin errors++; $display("FAIL floor_hold got %0d exp 0", level); end
    checks++; if (sb_bad + timeouts !== 0) begin errors++; $display("FAIL floor_sb got %0d exp 0", sb_bad + timeouts); end
  endtask

  task automatic test_enable();
    apply_reset();
    inc = 1'b1;
    repeat (15) @(posedge clk); #1;
    en = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (level !== 8'd128) begin errors++; $display("FAIL en_freeze got %0d exp 128", level); end
    en = 1'b1;
    @(posedge clk); #1;
    checks++; if (level !== 8'd129) begin errors++; $display("FAIL en_resume got %0d exp 129", level); end
    checks++; if (exp_q.size() !== 1) begin errors++; $display("FAIL en_resume_sb got %0d exp 1", exp_q.size()); end
    else void'(exp_q.pop_front());
  endtask

  task automatic test_drift_reset();
    apply_reset();
    inc = 1'b1; fast = 1'b0;
    advance(12);
    inc = 1'b0;
    advance(8);
    checks++; if (level !== 8'd139) begin errors++; $display("FAIL drift_first got %0d exp 139", level); end
    advance(88);
    checks++; if (level !== 8'd128) begin errors++; $display("FAIL drift_base got %0d exp 128", level); end
    advance(16);
    checks++; if (level !== 8'd128) begin errors++; $display("FAIL drift_stable got %0d exp 128", level); end
    inc = 1'b1;
    advance(5);
    inc = 1'b0;
    advance(12);
    checks++; if (level !== 8'd132) begin errors++; $display("FAIL drift_mid got %0d exp 132", level); end
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++; if ({level, level_q, changed} !== {8'd128, 2'd2, 1'b0}) begin errors++; $display("FAIL async_reset got %0d/%0d/%b exp 128/2/0", level, level_q, changed); end
    @(negedge clk);
    rst = 1'b0;
    checks++; if (sb_bad + timeouts !== 0) begin errors++; $display("FAIL drift_sb got %0d exp 0", sb_bad + timeouts); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; inc = 1'b0; dec = 1'b0; fast = 1'b0;
    test_reset();
    test_slow_inc();
    test_fast_sat();
    test_hysteresis();
    test_priority_floor();
    test_enable();
    test_drift_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
